plic_gateway: RTL and testbench



---
 rtl/plic_gateway.sv | 118 +++++++++++
 tb/tb_plic_gateway.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/plic_gateway.sv
// Per-source PLIC interrupt gateway: synchronizes 128 raw lines and turns
// level or edge activity into one-cycle requests held off until completion.
module plic_gateway #(
    parameter int CNT_W = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [127:0] src_irq,
    input  logic [127:0] src_edge,
    input  logic [127:0] int_end,
    output logic [127:0] int_req_pack,
    output logic         gateway_notif,
    output logic [127:0] gw_busy
);

    localparam int N = 128;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } st_e;

    logic [N-1:0]     s1_q, s1_d;
    logic [N-1:0]     s2_q, s2_d;
    logic [N-1:0]     s3_q, s3_d;
    st_e              st_q  [N];
    st_e              st_d  [N];
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [N-1:0]     req_q, req_d;
    logic             notif_q, notif_d;
    logic [N-1:0]     edge_det;
    logic [N-1:0]     level;

    assign edge_det = s2_q & ~s3_q;
    assign level    = s2_q;

    always_comb begin
        s1_d = src_irq;
        s2_d = s1_q;
        s3_d = s2_q;
        req_d = '0;
        for (int i = 0; i < N; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            if (i == 0) begin
                // source 0 is reserved and can never request
                st_d[i]  = IDLE;
                cnt_d[i] = '0;
            end else begin
                unique case (st_q[i])
                    IDLE: begin
                        if (src_edge[i]) begin
                            if (edge_det[i] || cnt_q[i] != '0) begin
                                req_d[i] = 1'b1;
                                st_d[i]  = WAIT;
                            end
                            if (cnt_q[i] != '0 && !edge_det[i]) begin
                                cnt_d[i] = cnt_q[i] - CNT_ONE;
                            end
                        end else if (level[i]) begin
                            req_d[i] = 1'b1;
                            st_d[i]  = WAIT;
                        end
                    end
                    WAIT: begin
                        if (src_edge[i] && edge_det[i] && cnt_q[i] != CNT_MAX) begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                        if (int_end[i]) begin
                            st_d[i] = IDLE;
                        end
                    end
                endcase
                if (!src_edge[i]) begin
                    cnt_d[i] = '0;
                end
            end
        end
        notif_d = |req_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            req_q   <= '0;
            notif_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                st_q[i]  <= IDLE;
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            req_q   <= req_d;
            notif_q <= notif_d;
            for (int i = 0; i < N; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            gw_busy[i] = (st_q[i] == WAIT);
        end
    end

    assign int_req_pack  = req_q;
    assign gateway_notif = notif_q;

endmodule

// File: tb/tb_plic_gateway.sv
// Randomized and directed bench for plic_gateway against an issue/replay
// model built from per-source busy flags and pending-edge counts.
module tb_plic_gateway;

    localparam int CNT_W = 2;
    localparam int PMAX  = (1 << CNT_W) - 1;

    logic         clk;
    logic         rstn;
    logic [127:0] src_irq;
    logic [127:0] src_edge;
    logic [127:0] int_end;
    logic [127:0] int_req_pack;
    logic         gateway_notif;
    logic [127:0] gw_busy;

    plic_gateway #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .src_irq      (src_irq),
        .src_edge     (src_edge),
        .int_end      (int_end),
        .int_req_pack (int_req_pack),
        .gateway_notif(gateway_notif),
        .gw_busy      (gw_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: delayed input copies, busy flag, pending edge count
    logic [127:0] d1, d2, d3;
    logic [127:0] mbusy;
    int           mpend [128];
    logic [127:0] mreq;
    logic         mnotif;
    int           obs   [128];
    logic         seen0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        d1 = '0; d2 = '0; d3 = '0;
        mbusy = '0; mreq = '0; mnotif = 1'b0;
        for (int i = 0; i < 128; i++) mpend[i] = 0;
    endtask

    task automatic model_step();
        logic [127:0] nreq;
        nreq = '0;
        for (int i = 1; i < 128; i++) begin
            bit rise;
            bit issue;
            rise = d2[i] & ~d3[i];
            if (!mbusy[i]) begin
                issue = src_edge[i] ? (rise || mpend[i] > 0) : d2[i];
                if (issue) begin
                    nreq[i]  = 1'b1;
                    mbusy[i] = 1'b1;
                end
                if (src_edge[i] && mpend[i] > 0 && !rise) mpend[i]--;
            end else begin
                if (src_edge[i] && rise && mpend[i] < PMAX) mpend[i]++;
                if (int_end[i]) mbusy[i] = 1'b0;
            end
            if (!src_edge[i]) mpend[i] = 0;
        end
        mreq   = nreq;
        mnotif = |nreq;
        d3 = d2;
        d2 = d1;
        d1 = src_irq;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("req", int_req_pack, mreq);
        chk("notif", {127'd0, gateway_notif}, {127'd0, mnotif});
        chk("busy", gw_busy, mbusy);
        for (int i = 0; i < 128; i++) if (int_req_pack[i]) obs[i]++;
        if (int_req_pack[0] || gw_busy[0]) seen0 = 1'b1;
    endtask

    task automatic pulse_end(input logic [127:0] m);
        int_end = m;
        tick();
        int_end = '0;
    endtask

    logic [127:0] mask;
    int           base;

    initial begin
        rstn = 1'b0;
        src_irq = '0; src_edge = '0; int_end = '0;
        seen0 = 1'b0;
        for (int i = 0; i < 128; i++) obs[i] = 0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_req", int_req_pack, '0);
        chk("rst_busy", gw_busy, '0);
        rstn = 1'b1;
        repeat (3) tick();

        // level source 5
        src_irq[5] = 1'b1;
        tick(); tick();
        chk("lvl5_early", {127'd0, int_req_pack[5]}, 128'd0);
        tick();
        chk("lvl5_first", {127'd0, int_req_pack[5]}, 128'd1);
        repeat (6) tick();
        chk("lvl5_hold", obs[5], 1);
        pulse_end(128'd1 << 5);
        tick();
        chk("lvl5_reissue", {127'd0, int_req_pack[5]}, 128'd1);
        src_irq[5] = 1'b0;
        repeat (4) tick();
        pulse_end(128'd1 << 5);
        repeat (6) tick();
        chk("lvl5_count", obs[5], 2);

        // edge source 40: 6 rises, 5 of them while busy
        src_edge[40] = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            src_irq[40] = 1'b1; tick(); tick();
            src_irq[40] = 1'b0; tick(); tick();
        end
        repeat (3) tick();
        chk("edge40_first", obs[40], 1);
        for (int k = 0; k < 4; k++) begin
            pulse_end(128'd1 << 40);
            tick();
            chk("edge40_replay", {127'd0, int_req_pack[40]},
                {127'd0, (k < PMAX)});
            repeat (2) tick();
        end
        chk("edge40_count", obs[40], 1 + ((5 < PMAX) ? 5 : PMAX));

        // simultaneous level sources
        mask = '0;
        mask[1] = 1'b1; mask[33] = 1'b1; mask[127] = 1'b1;
        src_irq = src_irq | mask;
        tick(); tick(); tick();
        chk("simul_req", int_req_pack, mask);
        chk("simul_notif", {127'd0, gateway_notif}, 128'd1);
        chk("simul_busy", gw_busy & mask, mask);
        src_irq = src_irq & ~mask;
        repeat (4) tick();
        pulse_end(mask);
        repeat (3) tick();

        // reserved source 0
        for (int k = 0; k < 8; k++) begin
            src_irq[0] = ~src_irq[0];
            src_edge[0] = k[1];
            if (k[0]) pulse_end(128'd1); else tick();
        end
        src_irq[0] = 1'b0;
        repeat (4) tick();

        // spurious completion and edge->level with two pending edges
        base = obs[9];
        pulse_end(128'd1 << 9);
        repeat (3) tick();
        chk("spur9_busy", {127'd0, gw_busy[9]}, 128'd0);
        chk("spur9_req", obs[9], base);
        src_edge[9] = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            src_irq[9] = 1'b1; tick(); tick();
            src_irq[9] = 1'b0; tick(); tick();
        end
        src_edge[9] = 1'b0;
        tick();
        pulse_end(128'd1 << 9);
        repeat (6) tick();
        chk("mode9_count", obs[9], base + 1);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 128; i++) begin
                if ($urandom_range(0, 7) == 0) src_irq[i] = ~src_irq[i];
                if ($urandom_range(0, 199) == 0) src_edge[i] = ~src_edge[i];
                if (mbusy[i]) int_end[i] = ($urandom_range(0, 3) == 0);
                else int_end[i] = ($urandom_range(0, 31) == 0);
            end
            tick();
        end
        int_end = '0;

        // reset mid-operation
        #1 rstn = 1'b0;
        #1;
        chk("midrst_req", int_req_pack, '0);
        chk("midrst_notif", {127'd0, gateway_notif}, 128'd0);
        chk("midrst_busy", gw_busy, '0);
        src_irq = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("post_rst_req", int_req_pack, '0);
        end
        chk("src0_never", {127'd0, seen0}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
